// File: rtl/sys_arr_mac_seq.sv
// ---------------------------------------------------------------------------
// sys_arr_mac_seq
//   Sequencer for an N x N systolic MAC array. A job loads N weight rows,
//   streams nvec input vectors through the array, drains the pipeline with
//   N-1 zero vectors and then pulses done.
//
//   Handshakes: a transfer happens in a cycle where both valid and ready are
//   high. Ready never depends on the matching valid. cmd_ready, w_ready and
//   in_ready come from registered state only.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready  job request; cmd_nvec is latched on accept
//   w_valid/ready    one weight row per transfer (LOAD_W only)
//   in_valid/ready   one input vector per transfer (STREAM, no op in flight)
//   mac_value_ready  AND of every MAC's value_ready flag
//   abort            synchronous job cancel
//   weight_en        MAC bus select: 1 = weights, 0 = inputs
//   mac_start        one-cycle start pulse for a MAC operation
//   mac_count        cycle count of the current MAC operation
//   mac_shift        one-cycle shift pulse towards the next MAC
//   zero_fill        forces a zero input vector while draining
//   busy             high outside IDLE
//   done             one-cycle job-complete pulse
// ---------------------------------------------------------------------------
module sys_arr_mac_seq #(
    parameter int N       = 4,
    parameter int MUL_LEN = 2,
    parameter int ADD_LEN = 3,
    localparam int L      = MUL_LEN + ADD_LEN,
    localparam int CW     = $clog2(L) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [7:0]    cmd_nvec,
    output logic          cmd_ready,
    input  logic          w_valid,
    output logic          w_ready,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mac_value_ready,
    input  logic          abort,
    output logic          weight_en,
    output logic          mac_start,
    output logic [CW-1:0] mac_count,
    output logic          mac_shift,
    output logic          zero_fill,
    output logic          busy,
    output logic          done
);

    localparam int RW = $clog2(N) + 1;
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
    localparam logic [RW-1:0] DRAIN_LAST = (N > 1) ? RW'(N - 2) : '0;
    localparam logic [CW-1:0] CNT_LAST   = CW'(L - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    // With a single-row array there is nothing to drain.
    localparam state_t AFTER_INPUTS = (N > 1) ? S_DRAIN : S_FIN;

    state_t        state;
    state_t        state_next;
    logic [7:0]    nvec;
    logic [7:0]    vec_cnt;
    logic [RW-1:0] row_cnt;
    logic [RW-1:0] drain_cnt;
    logic          op_active;

    logic          abort_job;
    logic          w_acc;
    logic          in_acc;
    logic          op_end;
    logic          last_vec;
    logic          start_next;

    assign abort_job = abort && (state != S_IDLE);
    assign w_acc     = (state == S_LOAD_W) && w_valid;
    assign in_acc    = in_ready && in_valid;
    // The operation finishes in the very cycle the MACs report ready, so the
    // shift is gated directly by mac_value_ready rather than a cycle later.
    assign op_end    = op_active && (mac_count == CNT_LAST) && mac_value_ready;
    assign last_vec  = (vec_cnt + 8'd1) == nvec;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (cmd_valid) state_next = S_LOAD_W;
            S_LOAD_W: if (w_acc && (row_cnt == ROW_LAST))
                          state_next = (nvec != 8'd0) ? S_STREAM : AFTER_INPUTS;
            S_STREAM: if (op_end && last_vec) state_next = AFTER_INPUTS;
            S_DRAIN:  if (op_end && (drain_cnt == DRAIN_LAST)) state_next = S_FIN;
            S_FIN:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort_job) state_next = S_IDLE;
    end

    // Output decode
    always_comb begin
        cmd_ready = (state == S_IDLE);
        w_ready   = (state == S_LOAD_W);
        weight_en = (state == S_LOAD_W);
        in_ready  = (state == S_STREAM) && !op_active;
        zero_fill = (state == S_DRAIN);
        busy      = (state != S_IDLE);
        done      = (state == S_FIN);
        mac_shift = w_acc || op_end;
    end

    // A MAC start follows an input handshake, entry into DRAIN (the previous
    // shift was the last weight row or the last input op), or a drain shift
    // that is not the final one.
    always_comb begin
        start_next = (in_acc && !abort_job)
                  || ((state_next == S_DRAIN) && (state != S_DRAIN))
                  || ((state == S_DRAIN) && (state_next == S_DRAIN) && op_end);
    end

    // Datapath: counters, operation tracking and the registered MAC controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nvec      <= '0;
            vec_cnt   <= '0;
            row_cnt   <= '0;
            drain_cnt <= '0;
            op_active <= 1'b0;
            mac_start <= 1'b0;
            mac_count <= '0;
        end else if (abort_job) begin
            vec_cnt   <= '0;
            row_cnt   <= '0;
            drain_cnt <= '0;
            op_active <= 1'b0;
            mac_start <= 1'b0;
            mac_count <= '0;
        end else begin
            mac_start <= start_next;
            if ((state == S_IDLE) && cmd_valid) begin
                nvec      <= cmd_nvec;
                vec_cnt   <= '0;
                row_cnt   <= '0;
                drain_cnt <= '0;
            end
            if (w_acc) begin
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
            end
            if (op_end && (state == S_STREAM)) vec_cnt <= vec_cnt + 8'd1;
            if (op_end && (state == S_DRAIN)) drain_cnt <= drain_cnt + RW'(1);
            if (state == S_FIN) begin
                vec_cnt   <= '0;
                drain_cnt <= '0;
            end
            // Count restarts at 0 in the start cycle, saturates at L-1 while
            // waiting for the MACs, and rests at 0 between operations.
            if (start_next) begin
                op_active <= 1'b1;
                mac_count <= '0;
            end else if (op_end) begin
                op_active <= 1'b0;
                mac_count <= '0;
            end else if (op_active && (mac_count != CNT_LAST)) begin
                mac_count <= mac_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sys_arr_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_sys_arr_mac_seq
//   Self-checking bench for sys_arr_mac_seq (N=4, L=5). For every job an
//   event-timeline model predicts the full per-cycle output trace from the
//   pre-generated input streams; the trace is queued and compared cycle by
//   cycle. Scenario tasks add targeted checks on observed event counts.
// ---------------------------------------------------------------------------
module tb_sys_arr_mac_seq;

    localparam int N       = 4;
    localparam int MUL_LEN = 2;
    localparam int ADD_LEN = 3;
    localparam int L       = MUL_LEN + ADD_LEN;
    localparam int CW      = $clog2(L) + 1;
    localparam int W       = 9 + CW;
    localparam int MAXC    = 400;

    // Bit positions in the packed output vector
    localparam int B_CR = W - 1;
    localparam int B_WR = W - 2;
    localparam int B_WE = W - 3;
    localparam int B_IR = W - 4;
    localparam int B_MS = W - 5;
    localparam int B_SH = W - 6;
    localparam int B_ZF = W - 7;
    localparam int B_BZ = W - 8;
    localparam int B_DN = W - 9;
    localparam logic [W-1:0] IDLE_V = {1'b1, {(W-1){1'b0}}};

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [7:0]    cmd_nvec = 8'd0;
    logic          w_valid = 1'b0;
    logic          in_valid = 1'b0;
    logic          mac_value_ready = 1'b0;
    logic          abort = 1'b0;
    logic          cmd_ready, w_ready, in_ready, weight_en, mac_start;
    logic          mac_shift, zero_fill, busy, done;
    logic [CW-1:0] mac_count;

    always #5 clk = ~clk;

    sys_arr_mac_seq #(.N(N), .MUL_LEN(MUL_LEN), .ADD_LEN(ADD_LEN)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_nvec(cmd_nvec), .cmd_ready(cmd_ready),
        .w_valid(w_valid), .w_ready(w_ready),
        .in_valid(in_valid), .in_ready(in_ready),
        .mac_value_ready(mac_value_ready), .abort(abort),
        .weight_en(weight_en), .mac_start(mac_start), .mac_count(mac_count),
        .mac_shift(mac_shift), .zero_fill(zero_fill), .busy(busy), .done(done)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    bit wv[MAXC];
    bit iv[MAXC];
    bit vr[MAXC];
    logic [W-1:0] exp_v[MAXC];
    logic [W-1:0] exp_q[$];
    int st_cyc[$];
    int drain_first;
    int fin_c;

    // Observed statistics of the most recent job
    int o_wshift, o_start_in, o_start_zf, o_done, o_in_ready, o_first_shift;
    int o_starts[$];

    function automatic logic [W-1:0] observed();
        return {cmd_ready, w_ready, weight_en, in_ready, mac_start, mac_shift,
                zero_fill, busy, done, mac_count};
    endfunction

    // ---------------- reference model ----------------
    // One MAC operation starting at cycle st: count climbs to L-1 and holds,
    // the shift lands in the first cycle at L-1 with value_ready high.
    function automatic int model_op(input int st, input bit zf);
        int c;
        c = st;
        exp_v[st][B_MS] = 1'b1;
        while (c < MAXC - 4) begin
            exp_v[c][B_BZ] = 1'b1;
            exp_v[c][B_ZF] = zf;
            exp_v[c][CW-1:0] = CW'(((c - st) < L - 1) ? (c - st) : (L - 1));
            if ((c - st) >= L - 1 && vr[c]) begin
                exp_v[c][B_SH] = 1'b1;
                return c;
            end
            c++;
        end
        return c;
    endfunction

    task automatic build_model(input int nvec);
        int c, acc, t, h, s;
        for (int i = 0; i < MAXC; i++) exp_v[i] = '0;
        st_cyc.delete();
        exp_v[0][B_CR] = 1'b1;
        // Weight load: N accepted rows, each shifted in its accept cycle
        c = 1;
        acc = 0;
        while (acc < N && c < MAXC - 40) begin
            exp_v[c][B_BZ] = 1'b1;
            exp_v[c][B_WR] = 1'b1;
            exp_v[c][B_WE] = 1'b1;
            if (wv[c]) begin
                exp_v[c][B_SH] = 1'b1;
                acc++;
            end
            c++;
        end
        t = c;
        // Streaming: wait for the handshake, start the op the cycle after
        for (int k = 0; k < nvec; k++) begin
            h = t;
            while (!iv[h] && h < MAXC - 40) begin
                exp_v[h][B_BZ] = 1'b1;
                exp_v[h][B_IR] = 1'b1;
                h++;
            end
            exp_v[h][B_BZ] = 1'b1;
            exp_v[h][B_IR] = 1'b1;
            st_cyc.push_back(h + 1);
            s = model_op(h + 1, 1'b0);
            t = s + 1;
        end
        // Drain: N-1 zero-fill ops, each started right after the last shift
        drain_first = t;
        for (int d = 0; d < N - 1; d++) begin
            s = model_op(t, 1'b1);
            t = s + 1;
        end
        exp_v[t][B_BZ] = 1'b1;
        exp_v[t][B_DN] = 1'b1;
        fin_c = t;
        exp_v[t + 1][B_CR] = 1'b1;
    endtask

    // wmode: 0 all high, 1 toggling 1,0,1,0 from cycle 1, 2 random
    // imode/vmode: 0 always high, 1 random
    task automatic gen_inputs(input int wmode, input int imode, input int vmode);
        for (int c = 0; c < MAXC; c++) begin
            wv[c] = (wmode == 0) ? 1'b1 : (wmode == 1) ? bit'(c % 2 == 1)
                                                       : bit'($urandom_range(0, 1));
            iv[c] = (imode == 0) ? 1'b1 : bit'($urandom_range(0, 2) != 0);
            vr[c] = (vmode == 0) ? 1'b1 : bit'($urandom_range(0, 3) != 0);
        end
    endtask

    // ---------------- driver ----------------
    // cut_mode: 0 full job, 1 abort during the 2nd input op, 2 reset in DRAIN
    task automatic run_job(input int nvec, input int cut_mode);
        int last, abort_at, rst_at;
        logic [W-1:0] expv, obs;
        build_model(nvec);
        last = fin_c + 1;
        abort_at = -1;
        rst_at = -1;
        if (cut_mode == 1 && st_cyc.size() > 1) begin
            abort_at = st_cyc[1] + 1;
            last = abort_at + 1;
            exp_v[last] = IDLE_V;
        end
        if (cut_mode == 2) begin
            rst_at = drain_first + 2;
            last = rst_at + 1;
            exp_v[last] = IDLE_V;
        end
        exp_q.delete();
        for (int c = 0; c <= last; c++) exp_q.push_back(exp_v[c]);
        o_wshift = 0; o_start_in = 0; o_start_zf = 0; o_done = 0;
        o_in_ready = 0; o_first_shift = -1;
        o_starts.delete();

        for (int c = 0; c <= last; c++) begin
            cmd_valid = (c == 0) ? 1'b1 : (c == last) ? 1'b0 : 1'($urandom_range(0, 1));
            cmd_nvec = (c == 0) ? 8'(nvec) : 8'($urandom_range(0, 255));
            w_valid = wv[c];
            in_valid = iv[c];
            mac_value_ready = vr[c];
            abort = (c == abort_at);
            expv = exp_q.pop_front();
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if (observed() !== IDLE_V)
                    $display("FAIL async_reset cyc=%0d got=%b exp=%b", c, observed(), IDLE_V);
                @(posedge clk);
                #1 rst = 1'b0;
            end else begin
                @(negedge clk);
                obs = observed();
                checks++;
                if (obs !== expv) begin
                    failures++;
                    $display("FAIL job_trace nvec=%0d cyc=%0d got=%b exp=%b", nvec, c, obs, expv);
                end
                if (weight_en && mac_shift) o_wshift++;
                if (mac_start && zero_fill) o_start_zf++;
                if (mac_start && !zero_fill) begin
                    o_start_in++;
                    o_starts.push_back(c);
                end
                if (done) o_done++;
                if (in_ready) o_in_ready++;
                if (mac_shift && !weight_en && !zero_fill && o_first_shift < 0) o_first_shift = c;
                @(posedge clk);
                #1;
            end
        end
        cmd_valid = 1'b0;
        abort = 1'b0;
        w_valid = 1'b0;
        in_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (observed() !== IDLE_V) begin
            failures++;
            $display("FAIL reset_async got=%b exp=%b", observed(), IDLE_V);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (observed() !== IDLE_V) begin
            failures++;
            $display("FAIL reset_held got=%b exp=%b", observed(), IDLE_V);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (observed() !== IDLE_V) begin
            failures++;
            $display("FAIL reset_release got=%b exp=%b", observed(), IDLE_V);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        gen_inputs(0, 0, 0);
        run_job(2, 0);
        checks++;
        if (o_wshift !== 4) begin
            failures++;
            $display("FAIL basic_weight_shifts got=%0d exp=4", o_wshift);
        end
        checks++;
        if (o_start_in !== 2) begin
            failures++;
            $display("FAIL basic_input_starts got=%0d exp=2", o_start_in);
        end
        checks++;
        if (o_starts.size() < 2 || (o_starts[1] - o_starts[0]) !== 6) begin
            failures++;
            $display("FAIL basic_start_spacing got=%0d exp=6",
                     (o_starts.size() < 2) ? -1 : o_starts[1] - o_starts[0]);
        end
        checks++;
        if (o_start_zf !== 3) begin
            failures++;
            $display("FAIL basic_drain_starts got=%0d exp=3", o_start_zf);
        end
        checks++;
        if (o_done !== 1) begin
            failures++;
            $display("FAIL basic_done_pulses got=%0d exp=1", o_done);
        end
    endtask

    task automatic test_stall();
        int s1;
        gen_inputs(0, 0, 0);
        build_model(2);
        s1 = st_cyc[0] + L - 1;
        for (int i = 0; i < 3; i++) vr[s1 + i] = 1'b0;
        run_job(2, 0);
        checks++;
        if (o_first_shift !== N + L + 1 + 3) begin
            failures++;
            $display("FAIL stall_shift_cycle got=%0d exp=%0d", o_first_shift, N + L + 4);
        end
        checks++;
        if (o_in_ready !== 2) begin
            failures++;
            $display("FAIL stall_in_ready_cycles got=%0d exp=2", o_in_ready);
        end
    endtask

    task automatic test_nvec_zero();
        gen_inputs(0, 0, 0);
        run_job(0, 0);
        checks++;
        if (o_in_ready !== 0) begin
            failures++;
            $display("FAIL nvec0_in_ready got=%0d exp=0", o_in_ready);
        end
        checks++;
        if (o_start_zf !== 3) begin
            failures++;
            $display("FAIL nvec0_drain_starts got=%0d exp=3", o_start_zf);
        end
    endtask

    task automatic test_abort();
        gen_inputs(0, 1, 1);
        run_job(3, 1);
        checks++;
        if (o_done !== 0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d exp=0", o_done);
        end
        gen_inputs(2, 1, 1);
        run_job(2, 0);
        checks++;
        if (o_done !== 1) begin
            failures++;
            $display("FAIL abort_next_job_done got=%0d exp=1", o_done);
        end
    endtask

    task automatic test_reset_drain();
        gen_inputs(0, 0, 1);
        run_job(1, 2);
        checks++;
        if (o_done !== 0) begin
            failures++;
            $display("FAIL rst_drain_no_done got=%0d exp=0", o_done);
        end
        gen_inputs(2, 1, 1);
        run_job(3, 0);
        checks++;
        if (o_done !== 1) begin
            failures++;
            $display("FAIL rst_drain_next_done got=%0d exp=1", o_done);
        end
    endtask

    task automatic test_w_toggle();
        gen_inputs(1, 0, 0);
        run_job(1, 0);
        checks++;
        if (o_wshift !== 4) begin
            failures++;
            $display("FAIL wtoggle_shifts got=%0d exp=4", o_wshift);
        end
    endtask

    task automatic test_back_to_back();
        int nv;
        repeat (6) begin
            nv = $urandom_range(0, 5);
            gen_inputs(2, 1, 1);
            run_job(nv, 0);
            checks++;
            if (o_done !== 1) begin
                failures++;
                $display("FAIL b2b_done nvec=%0d got=%0d exp=1", nv, o_done);
            end
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_nvec_zero();
        test_abort();
        test_reset_drain();
        test_w_toggle();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "time limit reached");
    end

endmodule
